// File: rtl/unison_pkg.sv
// Shared definitions for the unison readout path: feedback pulse encoding,
// step decode and the output buffer state.
package unison_pkg;

    localparam logic [1:0] FB_UP = 2'b01;
    localparam logic [1:0] FB_DN = 2'b10;

    typedef enum logic {EMPTY, FULL} buf_state_e;

    // Both pulses at once cancel, as does no pulse.
    function automatic logic signed [1:0] decode_step(input logic [1:0] fb);
        case (fb)
            FB_UP:   return 2'sd1;
            FB_DN:   return -2'sd1;
            default: return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/updown_accum.sv
// Signed up/down accumulator with clear-on-frame-close.
// UNISON_ACC_SAT_EN selects symmetric saturation; otherwise the sum wraps.
module updown_accum
    import unison_pkg::*;
#(
    parameter int unsigned ACC_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [1:0]       step,
    output logic signed [ACC_W-1:0] acc_next
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W:0]   sum;

    // One guard bit so the range test sees the true sum before truncation.
    assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-1){step[1]}}, step};

`ifdef UNISON_ACC_SAT_EN
    localparam logic signed [ACC_W:0] Lim = (ACC_W+1)'((2 ** (ACC_W-1)) - 1);

    always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (sum > Lim) begin
            acc_next = Lim[ACC_W-1:0];
        end else if (sum < -Lim) begin
            acc_next = -Lim[ACC_W-1:0];
        end
    end
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= clr ? '0 : acc_next;
        end
    end

endmodule

// File: rtl/unison_readout_accum.sv
// Frame integrator for the unison I/Q feedback pulses with a one-entry output
// buffer. Accumulator saturation is selected by UNISON_ACC_SAT_EN.
module unison_readout_accum
    import unison_pkg::*;
#(
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk_master,
    input  logic             rst,
    input  logic             ud_en,
    input  logic [1:0]       read_out_I,
    input  logic [1:0]       read_out_Q,
    output logic [ACC_W-1:0] out_I,
    output logic [ACC_W-1:0] out_Q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    logic [1:0]              ri_q, rq_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    frame_close;
    logic                    drop;
    logic signed [ACC_W-1:0] next_i, next_q;
    buf_state_e              buf_q;

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            ri_q <= '0;
            rq_q <= '0;
        end else begin
            ri_q <= read_out_I;
            rq_q <= read_out_Q;
        end
    end

    assign frame_close = ud_en && (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign drop        = frame_close && (buf_q == FULL) && !out_ready;

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ud_en) begin
            cnt_q <= frame_close ? '0 : cnt_q + 1'b1;
        end
    end

    updown_accum #(
        .ACC_W (ACC_W)
    ) u_accum_i (
        .clk      (clk_master),
        .rst      (rst),
        .en       (ud_en),
        .clr      (frame_close),
        .step     (decode_step(ri_q)),
        .acc_next (next_i)
    );

    updown_accum #(
        .ACC_W (ACC_W)
    ) u_accum_q (
        .clk      (clk_master),
        .rst      (rst),
        .en       (ud_en),
        .clr      (frame_close),
        .step     (decode_step(rq_q)),
        .acc_next (next_q)
    );

    // A closing frame may replace a buffered one only if it is read this cycle.
    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            buf_q     <= EMPTY;
            out_I     <= '0;
            out_Q     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (buf_q)
                EMPTY: begin
                    if (frame_close) begin
                        out_I     <= next_i;
                        out_Q     <= next_q;
                        out_valid <= 1'b1;
                        buf_q     <= FULL;
                    end
                end
                FULL: begin
                    if (frame_close && out_ready) begin
                        out_I <= next_i;
                        out_Q <= next_q;
                    end else if (!frame_close && out_ready) begin
                        out_valid <= 1'b0;
                        buf_q     <= EMPTY;
                    end
                end
                default: begin
                    buf_q     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_unison_readout_accum.sv
// Scoreboard bench for unison_readout_accum: stimulus pushes expected frame
// totals, a negedge monitor pops them on each valid/ready transfer.
module tb_unison_readout_accum;

    localparam int unsigned ACC_W = 12;
    localparam int unsigned FL    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             ud_en;
    logic [1:0]       read_out_I, read_out_Q;
    logic [ACC_W-1:0] out_I, out_Q;
    logic             out_valid, out_ready, overrun, overrun_clr;

    // Small instance for the saturation / wrap case.
    logic             s_en;
    logic [1:0]       s_i, s_q;
    logic [3:0]       s_out_I, s_out_Q;
    logic             s_valid, s_overrun;

    logic en_prev;
    int   checks = 0;
    int   failures = 0;
    int   exp_i_q[$];
    int   exp_q_q[$];
    int   mon_i, mon_q;

    always #5 clk = ~clk;

    unison_readout_accum #(
        .ACC_W     (ACC_W),
        .FRAME_LEN (FL)
    ) dut (
        .clk_master  (clk),
        .rst         (rst),
        .ud_en       (ud_en),
        .read_out_I  (read_out_I),
        .read_out_Q  (read_out_Q),
        .out_I       (out_I),
        .out_Q       (out_Q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    unison_readout_accum #(
        .ACC_W     (4),
        .FRAME_LEN (16)
    ) dut_small (
        .clk_master  (clk),
        .rst         (rst),
        .ud_en       (s_en),
        .read_out_I  (s_i),
        .read_out_Q  (s_q),
        .out_I       (s_out_I),
        .out_Q       (s_out_Q),
        .out_valid   (s_valid),
        .out_ready   (1'b0),
        .overrun     (s_overrun),
        .overrun_clr (1'b0)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ud_en trails the data by one cycle so each enabled cycle consumes the
    // sample registered on the previous edge.
    task automatic smp(input logic en, input logic [1:0] i, input logic [1:0] q);
        read_out_I = i;
        read_out_Q = q;
        ud_en      = en_prev;
        en_prev    = en;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] i, input logic [1:0] q, input int n);
        for (int k = 0; k < n; k++) smp(1'b1, i, q);
    endtask

    task automatic push(input int ei, input int eq);
        exp_i_q.push_back(ei);
        exp_q_q.push_back(eq);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_i_q.size() == 0) begin
                chk("unexpected_frame", 1, 0);
            end else begin
                mon_i = exp_i_q.pop_front();
                mon_q = exp_q_q.pop_front();
                chk("frame_I", $signed(out_I), mon_i);
                chk("frame_Q", $signed(out_Q), mon_q);
            end
        end
    end

    initial begin
        rst = 1'b1; ud_en = 1'b0; en_prev = 1'b0;
        read_out_I = 2'b00; read_out_Q = 2'b00;
        out_ready = 1'b1; overrun_clr = 1'b0;
        s_en = 1'b0; s_i = 2'b00; s_q = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_I", int'(out_I), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        rst = 1'b0;

        // Basic frame: +5 -3 on I, cancelling pairs on Q.
        push(2, 0);
        send(2'b01, 2'b11, 5);
        send(2'b10, 2'b11, 3);
        smp(1'b0, 2'b00, 2'b00);
        smp(1'b0, 2'b00, 2'b00);

        // Pause mid-frame; data during the pause must be ignored.
        push(8, 0);
        send(2'b01, 2'b00, 4);
        for (int k = 0; k < 10; k++) smp(1'b0, 2'b01, 2'b00);
        send(2'b01, 2'b00, 4);
        chk("pause_no_early_valid", int'(out_valid), 0);
        smp(1'b0, 2'b00, 2'b00);
        smp(1'b0, 2'b00, 2'b00);

        // Overrun: two frames with no reader, the first is kept.
        out_ready = 1'b0;
        send(2'b01, 2'b10, 8);
        smp(1'b0, 2'b00, 2'b00);
        chk("ovr_first_valid", int'(out_valid), 1);
        chk("ovr_not_yet", int'(overrun), 0);
        send(2'b10, 2'b01, 8);
        smp(1'b0, 2'b00, 2'b00);
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_held_I", $signed(out_I), 8);
        chk("ovr_held_Q", $signed(out_Q), -8);
        push(8, -8);
        out_ready = 1'b1;
        smp(1'b0, 2'b00, 2'b00);
        out_ready = 1'b0;
        chk("ovr_drained", int'(out_valid), 0);
        overrun_clr = 1'b1;
        smp(1'b0, 2'b00, 2'b00);
        overrun_clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);

        // Frame close coinciding with a read of the buffered frame.
        push(4, 0);
        push(-8, 8);
        send(2'b01, 2'b11, 4);
        send(2'b00, 2'b00, 4);
        smp(1'b0, 2'b00, 2'b00);
        send(2'b10, 2'b01, 8);
        out_ready = 1'b1;
        smp(1'b0, 2'b00, 2'b00);
        chk("swap_valid", int'(out_valid), 1);
        smp(1'b0, 2'b00, 2'b00);
        chk("swap_no_overrun", int'(overrun), 0);

        // Reset mid-frame after three enabled cycles.
        send(2'b01, 2'b01, 4);
        rst = 1'b1;
        #1;
        chk("rst_out_I", int'(out_I), 0);
        chk("rst_out_Q", int'(out_Q), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        ud_en = 1'b0; en_prev = 1'b0;
        read_out_I = 2'b00; read_out_Q = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(8, 0);
        send(2'b01, 2'b00, 8);
        chk("rst_full_frame", int'(out_valid), 0);
        smp(1'b0, 2'b00, 2'b00);
        smp(1'b0, 2'b00, 2'b00);

        // ACC_W=4, 16 up-steps: saturate at +7 or wrap to 0.
        s_i = 2'b01;
        @(posedge clk);
        #1;
        s_en = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("sat_no_early_valid", int'(s_valid), 0);
        @(posedge clk);
        #1;
        s_en = 1'b0;
        chk("sat_valid", int'(s_valid), 1);
`ifdef UNISON_ACC_SAT_EN
        chk("sat_out_I", $signed(s_out_I), 7);
`else
        chk("wrap_out_I", $signed(s_out_I), 0);
`endif
        chk("sat_out_Q", $signed(s_out_Q), 0);
        chk("sat_overrun", int'(s_overrun), 0);

        chk("scoreboard_empty", exp_i_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
